// File: rtl/uart_cmd_ctrl.sv
// Command sequencer behind the UART receiver: parses SYNC/ADDR/DLO/DHI/CHK frames
// and issues one register write per valid frame. Optional UART_CMD_ECHO_EN adds a status echo.
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 23400,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_rx_ready,
    input  logic [7:0]  in_rx_data,
    output logic        out_wr_en,
    output logic [7:0]  out_wr_addr,
    output logic [15:0] out_wr_data,
    input  logic        in_wr_ack,
    output logic        out_busy,
    output logic        out_err_chk,
    output logic        out_err_timeout,
    output logic        out_overrun,
    output logic [7:0]  out_frame_cnt
`ifdef UART_CMD_ECHO_EN
    ,
    output logic        out_tx_start,
    output logic [7:0]  out_tx_data,
    input  logic        in_tx_busy
`endif
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DLO,
        S_DHI,
        S_CHK,
        S_WRITE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] idle_cnt;
    logic [7:0]       addr_q;
    logic [7:0]       dlo_q;
    logic [7:0]       dhi_q;

    logic frame_active_c;
    logic timeout_c;
    logic chk_ok_c;
    logic ack_done_c;

    // A strobe in the limit cycle takes priority over the timeout.
    assign frame_active_c = (state inside {S_ADDR, S_DLO, S_DHI, S_CHK});
    assign timeout_c      = frame_active_c && !in_rx_ready && (idle_cnt == CNT_LAST);
    assign chk_ok_c       = (in_rx_data == (addr_q ^ dlo_q ^ dhi_q));
    assign ack_done_c     = (state == S_WRITE) && in_wr_ack;

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state           <= S_IDLE;
            idle_cnt        <= '0;
            addr_q          <= '0;
            dlo_q           <= '0;
            dhi_q           <= '0;
            out_wr_en       <= 1'b0;
            out_wr_addr     <= '0;
            out_wr_data     <= '0;
            out_busy        <= 1'b0;
            out_err_chk     <= 1'b0;
            out_err_timeout <= 1'b0;
            out_overrun     <= 1'b0;
            out_frame_cnt   <= '0;
        end else begin
            out_err_chk     <= 1'b0;
            out_err_timeout <= 1'b0;
            out_overrun     <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (in_rx_ready && (in_rx_data == SYNC_BYTE)) begin
                        state    <= S_ADDR;
                        out_busy <= 1'b1;
                        idle_cnt <= '0;
                    end
                end
                S_ADDR: begin
                    if (in_rx_ready) begin
                        addr_q <= in_rx_data;
                        state  <= S_DLO;
                    end
                end
                S_DLO: begin
                    if (in_rx_ready) begin
                        dlo_q <= in_rx_data;
                        state <= S_DHI;
                    end
                end
                S_DHI: begin
                    if (in_rx_ready) begin
                        dhi_q <= in_rx_data;
                        state <= S_CHK;
                    end
                end
                S_CHK: begin
                    if (in_rx_ready) begin
                        if (chk_ok_c) begin
                            out_wr_addr <= addr_q;
                            out_wr_data <= {dhi_q, dlo_q};
                            out_wr_en   <= 1'b1;
                            state       <= S_WRITE;
                        end else begin
                            out_err_chk <= 1'b1;
                            out_busy    <= 1'b0;
                            state       <= S_IDLE;
                        end
                    end
                end
                S_WRITE: begin
                    // Bytes arriving while the write is outstanding are dropped.
                    if (in_rx_ready) begin
                        out_overrun <= 1'b1;
                    end
                    if (in_wr_ack) begin
                        out_wr_en     <= 1'b0;
                        out_frame_cnt <= out_frame_cnt + 8'd1;
                        out_busy      <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    out_busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase

            if (frame_active_c) begin
                idle_cnt <= in_rx_ready ? '0 : idle_cnt + 1'b1;
            end

            if (timeout_c) begin
                out_err_timeout <= 1'b1;
                out_busy        <= 1'b0;
                state           <= S_IDLE;
            end
        end
    end

`ifdef UART_CMD_ECHO_EN
    logic       chk_bad_c;
    logic       tx_pend;
    logic [7:0] tx_hold;

    assign chk_bad_c = (state == S_CHK) && in_rx_ready && !chk_ok_c;

    // One-deep status holding register; a newer status overwrites a pending one.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            tx_pend      <= 1'b0;
            tx_hold      <= '0;
            out_tx_start <= 1'b0;
            out_tx_data  <= '0;
        end else begin
            out_tx_start <= 1'b0;
            if (tx_pend && !in_tx_busy) begin
                out_tx_start <= 1'b1;
                out_tx_data  <= tx_hold;
                tx_pend      <= 1'b0;
            end
            if (ack_done_c) begin
                tx_pend <= 1'b1;
                tx_hold <= 8'h5A;
            end else if (chk_bad_c) begin
                tx_pend <= 1'b1;
                tx_hold <= 8'hE1;
            end else if (timeout_c) begin
                tx_pend <= 1'b1;
                tx_hold <= 8'hE2;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed vector table, hand sequences and a random run
// against a queue-based frame model.
module tb_uart_cmd_ctrl;

    localparam int unsigned T    = 50;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_d = 8'h00;
    logic        ack = 1'b0;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        err_chk;
    logic        err_to;
    logic        ovr;
    logic [7:0]  fcnt;
`ifdef UART_CMD_ECHO_EN
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    int          n_tx5a = 0;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(.TIMEOUT_CYCLES(T), .SYNC_BYTE(SYNC)) dut (
        .in_clk          (clk),
        .in_rst          (rst_n),
        .in_rx_ready     (rx_rdy),
        .in_rx_data      (rx_d),
        .out_wr_en       (wr_en),
        .out_wr_addr     (wr_addr),
        .out_wr_data     (wr_data),
        .in_wr_ack       (ack),
        .out_busy        (busy),
        .out_err_chk     (err_chk),
        .out_err_timeout (err_to),
        .out_overrun     (ovr),
        .out_frame_cnt   (fcnt)
`ifdef UART_CMD_ECHO_EN
        ,
        .out_tx_start    (tx_start),
        .out_tx_data     (tx_data),
        .in_tx_busy      (tx_busy)
`endif
    );

    // Reference model: pending write flag plus a queue of frame bytes collected so far.
    bit          m_wr;
    logic [7:0]  m_addr;
    logic [15:0] m_data;
    logic [7:0]  m_cnt;
    logic [7:0]  m_frame[$];
    int          m_gap;
    bit          m_chk, m_to, m_ovr;
`ifdef UART_CMD_ECHO_EN
    bit          m_pend, m_start;
    logic [7:0]  m_hold, m_txd;
`endif

    function automatic void model_reset();
        m_wr = 0; m_addr = '0; m_data = '0; m_cnt = '0; m_frame.delete(); m_gap = 0;
        m_chk = 0; m_to = 0; m_ovr = 0;
`ifdef UART_CMD_ECHO_EN
        m_pend = 0; m_start = 0; m_hold = '0; m_txd = '0;
`endif
    endfunction

    function automatic void model_step(bit r, logic [7:0] d, bit a);
        bit         push = 0;
        logic [7:0] st = 8'h00;
        m_chk = 0; m_to = 0; m_ovr = 0;
        if (m_wr) begin
            if (r) m_ovr = 1;
            if (a) begin m_wr = 0; m_cnt = m_cnt + 8'd1; push = 1; st = 8'h5A; end
        end else if (m_frame.size() == 0) begin
            if (r && d == SYNC) begin m_frame.push_back(d); m_gap = 0; end
        end else if (r) begin
            m_gap = 0;
            m_frame.push_back(d);
            if (m_frame.size() == 5) begin
                if ((m_frame[1] ^ m_frame[2] ^ m_frame[3]) == m_frame[4]) begin
                    m_wr = 1; m_addr = m_frame[1]; m_data = {m_frame[3], m_frame[2]};
                end else begin
                    m_chk = 1; push = 1; st = 8'hE1;
                end
                m_frame.delete();
            end
        end else if (m_gap == int'(T) - 1) begin
            m_to = 1; push = 1; st = 8'hE2; m_frame.delete();
        end else begin
            m_gap++;
        end
`ifdef UART_CMD_ECHO_EN
        m_start = 0;
        if (m_pend && !tx_busy) begin m_start = 1; m_txd = m_hold; m_pend = 0; end
        if (push) begin m_pend = 1; m_hold = st; end
`else
        if (push && st == 8'hFF) m_gap = 0;
`endif
    endfunction

    function automatic logic [36:0] dut_vec();
        return {wr_en, wr_addr, wr_data, busy, err_chk, err_to, ovr, fcnt};
    endfunction

    function automatic logic [36:0] model_vec();
        return {m_wr, m_addr, m_data, (m_wr || m_frame.size() != 0), m_chk, m_to, m_ovr, m_cnt};
    endfunction

    task automatic check(input string nm, input logic [36:0] got, input logic [36:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    task automatic check_model(input string nm);
        check(nm, dut_vec(), model_vec());
`ifdef UART_CMD_ECHO_EN
        n_vec++;
        if (tx_start !== m_start || (m_start && tx_data !== m_txd)) begin
            n_err++;
            $display("FAIL %s_echo @%0t: got start=%b data=%h expected start=%b data=%h",
                     nm, $time, tx_start, tx_data, m_start, m_txd);
        end
        if (tx_start && tx_data == 8'h5A) n_tx5a++;
`endif
    endtask

    // One clock: drive, step the model, sample 1 ns after the edge.
    task automatic cyc(input bit r, input logic [7:0] d, input bit a);
        rx_rdy = r; rx_d = d; ack = a;
        @(posedge clk);
        model_step(r, d, a);
        #1;
    endtask

    task automatic do_reset(input string nm);
        rx_rdy = 0; ack = 0;
        #2 rst_n = 0;
        #1 check(nm, dut_vec(), 37'd0);
`ifdef UART_CMD_ECHO_EN
        check({nm, "_tx"}, {35'd0, tx_start, tx_data != 8'h00}, 37'd0);
`endif
        model_reset();
        #2 rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] lo, input logic [7:0] hi,
                              input logic [7:0] c, input bit ak, input string nm);
        cyc(1, SYNC, ak); check_model(nm);
        cyc(1, a, ak);    check_model(nm);
        cyc(1, lo, ak);   check_model(nm);
        cyc(1, hi, ak);   check_model(nm);
        cyc(1, c, ak);    check_model(nm);
    endtask

    typedef struct {
        bit          r;
        logic [7:0]  d;
        bit          a;
        logic [36:0] exp;
    } vec_t;

    function automatic vec_t mk(bit r, logic [7:0] d, bit a, bit en, logic [7:0] ad,
                                logic [15:0] dt, bit bz, bit ck, bit to, bit ov, logic [7:0] cn);
        vec_t v;
        v.r = r; v.d = d; v.a = a;
        v.exp = {en, ad, dt, bz, ck, to, ov, cn};
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        model_reset();
        // Frame 10/34/12 (checksum 0x36), ack on the third wait cycle.
        tbl.push_back(mk(1, 8'hA5, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 8'd0));
        tbl.push_back(mk(1, 8'h10, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 8'd0));
        tbl.push_back(mk(1, 8'h34, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 8'd0));
        tbl.push_back(mk(1, 8'h12, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 8'd0));
        tbl.push_back(mk(1, 8'h36, 0, 1, 8'h10, 16'h1234, 1, 0, 0, 0, 8'd0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 8'h10, 16'h1234, 1, 0, 0, 0, 8'd0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 8'h10, 16'h1234, 1, 0, 0, 0, 8'd0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 8'h10, 16'h1234, 0, 0, 0, 0, 8'd1));
        // Bad checksum, then a stray ack in IDLE.
        tbl.push_back(mk(1, 8'hA5, 0, 0, 8'h10, 16'h1234, 1, 0, 0, 0, 8'd1));
        tbl.push_back(mk(1, 8'h10, 0, 0, 8'h10, 16'h1234, 1, 0, 0, 0, 8'd1));
        tbl.push_back(mk(1, 8'h34, 0, 0, 8'h10, 16'h1234, 1, 0, 0, 0, 8'd1));
        tbl.push_back(mk(1, 8'h12, 0, 0, 8'h10, 16'h1234, 1, 0, 0, 0, 8'd1));
        tbl.push_back(mk(1, 8'h00, 0, 0, 8'h10, 16'h1234, 0, 1, 0, 0, 8'd1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 8'h10, 16'h1234, 0, 0, 0, 0, 8'd1));
        // Leading junk, frame 01/02/03, overrun byte while waiting for ack.
        tbl.push_back(mk(1, 8'h00, 0, 0, 8'h10, 16'h1234, 0, 0, 0, 0, 8'd1));
        tbl.push_back(mk(1, 8'hFF, 0, 0, 8'h10, 16'h1234, 0, 0, 0, 0, 8'd1));
        tbl.push_back(mk(1, 8'hA5, 0, 0, 8'h10, 16'h1234, 1, 0, 0, 0, 8'd1));
        tbl.push_back(mk(1, 8'h01, 0, 0, 8'h10, 16'h1234, 1, 0, 0, 0, 8'd1));
        tbl.push_back(mk(1, 8'h02, 0, 0, 8'h10, 16'h1234, 1, 0, 0, 0, 8'd1));
        tbl.push_back(mk(1, 8'h03, 0, 0, 8'h10, 16'h1234, 1, 0, 0, 0, 8'd1));
        tbl.push_back(mk(1, 8'h00, 0, 1, 8'h01, 16'h0302, 1, 0, 0, 0, 8'd1));
        tbl.push_back(mk(1, 8'h55, 0, 1, 8'h01, 16'h0302, 1, 0, 0, 1, 8'd1));
        tbl.push_back(mk(1, 8'hA5, 0, 1, 8'h01, 16'h0302, 1, 0, 0, 1, 8'd1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 8'h01, 16'h0302, 1, 0, 0, 0, 8'd1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 8'h01, 16'h0302, 0, 0, 0, 0, 8'd2));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h01, 16'h0302, 0, 0, 0, 0, 8'd2));

        #12 check("reset_init", dut_vec(), 37'd0);
        rst_n = 1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].d, tbl[i].a);
            check($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
        end

        // Timeout after SYNC+ADDR: no pulse after T-1 silent clocks, pulse on the T-th.
        do_reset("reset_pre_to");
        cyc(1, SYNC, 0); cyc(1, 8'h10, 0);
        for (int i = 0; i < int'(T) - 1; i++) begin cyc(0, 8'h00, 0); check_model("to_wait"); end
        check("to_not_yet", {35'd0, busy, err_to}, {35'd0, 1'b1, 1'b0});
        cyc(0, 8'h00, 0);
        check("to_pulse", {35'd0, busy, err_to}, {35'd0, 1'b0, 1'b1});
        cyc(0, 8'h00, 0);
        check("to_single", {35'd0, busy, err_to}, 37'd0);
        send_frame(8'h20, 8'hCD, 8'hAB, 8'h20 ^ 8'hCD ^ 8'hAB, 1, "post_to");
        check("post_to_wr", {4'd0, wr_en, wr_addr, wr_data, fcnt}, {4'd0, 1'b1, 8'h20, 16'hABCD, 8'd0});
        cyc(0, 8'h00, 1); check_model("post_to_ack");

        // Byte arriving on the limit cycle wins over the timeout.
        cyc(1, SYNC, 0);
        for (int i = 0; i < int'(T) - 1; i++) cyc(0, 8'h00, 0);
        cyc(1, 8'h11, 0);
        check("byte_wins", {35'd0, busy, err_to}, {35'd0, 1'b1, 1'b0});
        for (int i = 0; i < int'(T); i++) begin cyc(0, 8'h00, 0); check_model("to_dlo"); end

        // Reset during DHI and during WRITE.
        cyc(1, SYNC, 0); cyc(1, 8'h10, 0); cyc(1, 8'h34, 0);
        do_reset("reset_in_dhi");
        for (int i = 0; i < 3; i++) begin
            cyc(0, 8'h00, 1);
            check("after_rst_dhi", {29'd0, wr_en, fcnt}, 37'd0);
        end
        send_frame(8'h10, 8'h34, 8'h12, 8'h36, 0, "pre_rst_wr");
        cyc(0, 8'h00, 0); check_model("pre_rst_wr_hold");
        do_reset("reset_in_write");
        for (int i = 0; i < 3; i++) begin
            cyc(0, 8'h00, 1);
            check("after_rst_wr", {29'd0, wr_en, fcnt}, 37'd0);
        end

        // 256 back-to-back frames with a same-cycle ack: counter wraps to 0.
`ifdef UART_CMD_ECHO_EN
        tx_busy = 0;
        n_tx5a = 0;
`endif
        for (int f = 0; f < 256; f++) begin
            logic [7:0] a, lo, hi;
            a = 8'($urandom); lo = 8'($urandom); hi = 8'($urandom);
            send_frame(a, lo, hi, a ^ lo ^ hi, 1, "wrap");
            cyc(0, 8'h00, 1); check_model("wrap_ack");
            if (f == 254) check("cnt_255", {29'd0, fcnt}, {29'd0, 8'd255});
        end
        check("cnt_wrap", {29'd0, fcnt}, 37'd0);
        cyc(0, 8'h00, 0); check_model("wrap_flush");
`ifdef UART_CMD_ECHO_EN
        check("tx_5a_count", 37'(n_tx5a), 37'd256);
`endif

        // Randomized traffic against the model.
        do_reset("reset_pre_rand");
        for (int n = 0; n < 3000; n++) begin
            bit         r, a;
            logic [7:0] d;
            a = ($urandom_range(0, 99) < 35);
`ifdef UART_CMD_ECHO_EN
            tx_busy = ($urandom_range(0, 1) == 1);
`endif
            if ($urandom_range(0, 149) == 0) begin
                int len = $urandom_range(int'(T) - 3, int'(T) + 2);
                for (int k = 0; k < len; k++) begin cyc(0, 8'h00, a); check_model("rand_gap"); end
            end
            r = ($urandom_range(0, 99) < 60);
            if (m_frame.size() == 0 && !m_wr && $urandom_range(0, 99) < 70) d = SYNC;
            else if (m_frame.size() == 4 && $urandom_range(0, 99) < 60) d = m_frame[1] ^ m_frame[2] ^ m_frame[3];
            else d = 8'($urandom);
            cyc(r, d, a);
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
